// File: rtl/mdl_cyclecntr.sv
`default_nettype none
// ============================================================================
//  Module   : mdl_cyclecntr
//  Purpose  : Timing source for bubble access control. Produces the 20-phase
//             active-low one-hot rotator (one step per 2 MHz tick) and a
//             bit-serial magnetic-field cycle counter. The counter is shown
//             LSB-first, one bit per rotator phase, and a parallel snapshot
//             is taken at phase 19.
//  Options  : CYCLECNTR_PRESET_EN adds a phase-19 synchronous preset load
//             (i_PRESET / i_PRESET_VAL).
//  Revision : 1.0  initial release
// ============================================================================
module mdl_cyclecntr #(
   parameter int CNTR_WIDTH = 10   // legal range 1..19
) (
   input  logic                  i_MCLK,
   input  logic                  i_SYS_RST_n,
   input  logic                  i_CLK2M_PCEN_n,
   input  logic                  i_HALT,
   input  logic                  i_CNT_EN,
   input  logic                  i_CNT_CLR,
`ifdef CYCLECNTR_PRESET_EN
   input  logic                  i_PRESET,
   input  logic [CNTR_WIDTH-1:0] i_PRESET_VAL,
`endif
   output logic [19:0]           o_ROT20_n,
   output logic                  o_CYCLECNTR_LSB,
   output logic [CNTR_WIDTH-1:0] o_CYCLECNT,
   output logic                  o_CNT_OVF
);

   // Phase index of the last serial bit, and of the rotation's final phase.
   localparam logic [4:0] c_last_bit   = 5'(CNTR_WIDTH - 1);
   localparam logic [4:0] c_phase_last = 5'd19;

   logic [19:0]           r_rot;
   logic [4:0]            r_phase;   // binary mirror of the rotator position
   logic [CNTR_WIDTH-1:0] r_sr;
   logic                  r_carry;
   logic                  r_clrp;
   logic [CNTR_WIDTH-1:0] r_cnt;
   logic                  r_ovf;

   logic                  w_tick;
   logic                  w_in_serial;
   logic [CNTR_WIDTH-1:0] w_sr_shift;
   logic [CNTR_WIDTH-1:0] w_sr_nxt;
   logic                  w_carry_nxt;
   logic                  w_clrp_nxt;
   logic [CNTR_WIDTH-1:0] w_cnt_nxt;
   logic                  w_ovf_nxt;

   assign w_tick      = ~i_CLK2M_PCEN_n;
   assign w_in_serial = (r_phase <= c_last_bit);

   // One serial-adder step: the sum bit enters at the top as the LSB leaves.
   generate
      if (CNTR_WIDTH == 1) begin : g_sr_w1
         assign w_sr_shift = r_sr[0] ^ r_carry;
      end else begin : g_sr_wn
         assign w_sr_shift = {r_sr[0] ^ r_carry, r_sr[CNTR_WIDTH-1:1]};
      end
   endgenerate

   // Next-state for the counter: serial add in the bit phases, bookkeeping at phase 19.
   always_comb begin
      w_sr_nxt    = r_sr;
      w_carry_nxt = r_carry;
      w_clrp_nxt  = r_clrp;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = 1'b0;
      if (w_in_serial) begin
         w_sr_nxt    = w_sr_shift;
         w_carry_nxt = r_carry & r_sr[0];
         if (r_phase == c_last_bit) begin
            w_ovf_nxt = r_carry & r_sr[0];
         end
      end
      if (r_phase == c_phase_last) begin
         if (r_clrp | i_CNT_CLR) begin
            w_sr_nxt    = '0;
            w_carry_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_clrp_nxt  = 1'b0;
         end
`ifdef CYCLECNTR_PRESET_EN
         else if (i_PRESET) begin
            w_sr_nxt    = i_PRESET_VAL;
            w_carry_nxt = 1'b0;
            w_cnt_nxt   = i_PRESET_VAL;
         end
`endif
         else begin
            w_carry_nxt = i_CNT_EN & ~i_HALT;
            w_cnt_nxt   = r_sr;
         end
      end else if (i_CNT_CLR) begin
         // Deferred so the rotation in progress is never corrupted.
         w_clrp_nxt = 1'b1;
      end
   end

   // State registers; everything advances only on 2 MHz ticks.
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
      if (!i_SYS_RST_n) begin
         r_rot   <= 20'hFFFFE;
         r_phase <= 5'd0;
         r_sr    <= '0;
         r_carry <= 1'b0;
         r_clrp  <= 1'b0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else if (w_tick) begin
         r_rot   <= {r_rot[18:0], r_rot[19]};
         r_phase <= (r_phase == c_phase_last) ? 5'd0 : r_phase + 5'd1;
         r_sr    <= w_sr_nxt;
         r_carry <= w_carry_nxt;
         r_clrp  <= w_clrp_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign o_ROT20_n       = r_rot;
   assign o_CYCLECNTR_LSB = w_in_serial & r_sr[0];
   assign o_CYCLECNT      = r_cnt;
   assign o_CNT_OVF       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mdl_cyclecntr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdl_cyclecntr
//  Purpose  : Self-checking bench for mdl_cyclecntr (default build). A
//             rotation-level model pushes expected outputs when each tick is
//             driven; they are popped and compared after the tick.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdl_cyclecntr;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pcen_n;
   logic          halt;
   logic          en;
   logic          clr;
   logic [19:0]   rot;
   logic          lsb;
   logic [W-1:0]  cnt;
   logic          ovf;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   typedef struct {
      logic [19:0]  rot;
      logic         lsb;
      logic [W-1:0] cnt;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];

   // Model state: value presented this rotation, increment flag, snapshot.
   int           m_phase;
   logic [W-1:0] m_val;
   logic [W-1:0] m_snap;
   logic         m_carry;
   logic         m_clrp;
   logic         m_ovf;

   always #5 clk = ~clk;

   mdl_cyclecntr #(.CNTR_WIDTH(W)) u_dut (
      .i_MCLK          (clk),
      .i_SYS_RST_n     (rst_n),
      .i_CLK2M_PCEN_n  (pcen_n),
      .i_HALT          (halt),
      .i_CNT_EN        (en),
      .i_CNT_CLR       (clr),
      .o_ROT20_n       (rot),
      .o_CYCLECNTR_LSB (lsb),
      .o_CYCLECNT      (cnt),
      .o_CNT_OVF       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_val   = '0;
      m_snap  = '0;
      m_carry = 1'b0;
      m_clrp  = 1'b0;
      m_ovf   = 1'b0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.rot = ~(20'd1 << m_phase);
      e.lsb = (m_phase < W) ? m_val[m_phase] : 1'b0;
      e.cnt = m_snap;
      e.ovf = m_ovf;
      return e;
   endfunction

   task automatic model_tick(input logic a_en, input logic a_clr, input logic a_halt);
      m_ovf = (m_phase == W - 1) && m_carry && (m_val == {W{1'b1}});
      if (m_phase == 19) begin
         if (m_clrp || a_clr) begin
            m_val   = '0;
            m_snap  = '0;
            m_carry = 1'b0;
            m_clrp  = 1'b0;
         end else begin
            m_val   = m_val + {{(W-1){1'b0}}, m_carry};
            m_snap  = m_val;
            m_carry = a_en & ~a_halt;
         end
      end else if (a_clr) begin
         m_clrp = 1'b1;
      end
      m_phase = (m_phase + 1) % 20;
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb_q.pop_front();
      check("rot", {12'd0, rot}, {12'd0, e.rot});
      check("onehot", $countones(~rot), 32'd1);
      check("lsb", {31'd0, lsb}, {31'd0, e.lsb});
      check("cnt", {22'd0, cnt}, {22'd0, e.cnt});
      check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
   endtask

   // Called at a negedge: tick on the next posedge, idle edge after, compare.
   task automatic tick(input logic a_en, input logic a_clr, input logic a_halt);
      en     = a_en;
      clr    = a_clr;
      halt   = a_halt;
      pcen_n = 1'b0;
      model_tick(a_en, a_clr, a_halt);
      sb_q.push_back(model_out());
      @(negedge clk);
      pcen_n = 1'b1;
      @(negedge clk);
      compare_out();
   endtask

   task automatic rotation(input logic a_en, input logic a_halt);
      for (int i = 0; i < 20; i++) tick(a_en, 1'b0, a_halt);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] pat;
      rst_n  = 1'b0;
      pcen_n = 1'b1;
      en     = 1'b0;
      clr    = 1'b0;
      halt   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_rot", {12'd0, rot}, 32'hFFFFE);
      check("rst_lsb", {31'd0, lsb}, 32'd0);
      check("rst_cnt", {22'd0, cnt}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);

      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_rot", {12'd0, rot}, 32'hFFFFE);

      // Rotator walk, then counting with enable held.
      rotation(1'b0, 1'b0);
      rotation(1'b1, 1'b0);
      repeat (5) rotation(1'b1, 1'b0);
      check("cnt5", {22'd0, cnt}, 32'd5);

      for (int g = 0; g < 100 && m_snap != 10'd37; g++) rotation(1'b1, 1'b0);
      check("reach37", {22'd0, cnt}, 32'd37);

      // Clear at phase 4 while incrementing.
      for (int i = 0; i < 20; i++) tick(1'b1, (i == 4), 1'b0);
      check("clr_snap", {22'd0, cnt}, 32'd0);
      rotation(1'b1, 1'b0);
      check("clr_after", {22'd0, cnt}, 32'd0);

      // Halt across phase 19 blocks only the next carry load.
      rotation(1'b1, 1'b1);
      check("halt_inflight", {22'd0, cnt}, 32'd1);
      rotation(1'b1, 1'b0);
      check("halt_hold", {22'd0, cnt}, 32'd1);

      // Count to 702 and check its serial image explicitly.
      for (int g = 0; g < 800 && m_snap != 10'd702; g++) rotation(1'b1, 1'b0);
      check("reach702", {22'd0, cnt}, 32'd702);
      pat = 10'h2BE;
      check("s702_b0", {31'd0, lsb}, {31'd0, pat[0]});
      for (int i = 1; i < W; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         check("s702_bit", {31'd0, lsb}, {31'd0, pat[i]});
      end
      for (int i = W; i <= 20; i++) tick(1'b1, 1'b0, 1'b0);

      // Run to 1023 and wrap.
      for (int g = 0; g < 400 && m_snap != 10'h3FF; g++) rotation(1'b1, 1'b0);
      check("reach1023", {22'd0, cnt}, 32'h3FF);
      for (int i = 0; i < W; i++) tick(1'b1, 1'b0, 1'b0);
      check("ovf_pulse", {31'd0, ovf}, 32'd1);
      tick(1'b1, 1'b0, 1'b0);
      check("ovf_clear", {31'd0, ovf}, 32'd0);
      for (int i = W + 1; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
      check("wrap_snap", {22'd0, cnt}, 32'd0);

      // Asynchronous reset in phase 12.
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rot", {12'd0, rot}, 32'hFFFFE);
      check("arst_cnt", {22'd0, cnt}, 32'd0);
      check("arst_ovf", {31'd0, ovf}, 32'd0);
      check("arst_lsb", {31'd0, lsb}, 32'd0);
      model_reset();
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rotation(1'b1, 1'b0);
      rotation(1'b1, 1'b0);
      check("post_rst", {22'd0, cnt}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
